mem_line_responder: RTL and testbench
=====================================

MEM_LINE_RESPONDER -- requirements
Module: mem_line_responder

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- WORD_W, 32, bits per word.
- LINE_WORDS, 8, words per cache line.
- LINE_ADDR_W, 8, line-address width; array holds 2**LINE_ADDR_W lines.
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, single clock; all state changes on its rising edge.
- rst, in, 1, asynchronous, active-low reset.
- mem_read, in, 1, one-cycle line-fill request from the cache controller.
- mem_write, in, 1, one-cycle line write-back request from the cache controller.
- line_addr, in, LINE_ADDR_W, line address, sampled with the request.
- wr_line, in, WORD_W*LINE_WORDS, write-back line, sampled with mem_write; word 0 in LSBs.
- rd_line, out, WORD_W*LINE_WORDS, fetched line; word 0 in LSBs.
- ca_resp, out, 1, one-cycle completion pulse for either request.
- busy, out, 1, high while a request is in progress.
- error, out, 1, one-cycle pulse for a rejected request.

Function
REQ-003 FSM states: IDLE, RD_BURST, WR_BURST, RESP. All outputs are registered.
REQ-004 IDLE, mem_read=1, mem_write=0: capture line_addr, clear beat counter, go to RD_BURST.
REQ-005 IDLE, mem_write=1, mem_read=0: capture line_addr and wr_line, clear beat counter, go to WR_BURST.
REQ-006 IDLE, both requests high: pulse error, stay in IDLE, do not access the array.
REQ-007 Any request seen outside IDLE: pulse error and drop the request; the burst in progress continues unchanged.
REQ-008 RD_BURST: one array read per cycle at word index {addr, beat}; each word goes into rd_line slot [beat].
REQ-009 WR_BURST: one array write per cycle of captured word [beat] to index {addr, beat}.
REQ-010 Beat counter is 3 bits (log2 LINE_WORDS); the burst ends when the counter wraps from 7 to 0, then the FSM goes to RESP.
REQ-011 RESP: ca_resp=1 for exactly one cycle, then go to IDLE.
REQ-012 Latency: request sampled at edge T gives ca_resp high in the cycle after edge T+9, i.e. 8 beats plus 1 response cycle. A new request is accepted at edge T+10 at the earliest.
REQ-013 busy=1 in RD_BURST, WR_BURST and RESP; busy=0 in IDLE.
REQ-014 rd_line holds its value from ca_resp of one read until the first beat of the next read; writes never change rd_line.
REQ-015 A read of a line written earlier returns that data, including when the read follows the write's ca_resp immediately.
REQ-016 Unused state encodings go to IDLE in one cycle and pulse error.

Reset
REQ-017 rst low asynchronously forces: state IDLE, beat counter 0, ca_resp 0, busy 0, error 0, rd_line all zeros.
REQ-018 Array contents are not reset. Reset during a write burst leaves the already-written words written and the rest unchanged.
REQ-019 Reset mid-burst produces no ca_resp. The first request after rst deasserts is handled normally.

Structure
REQ-020 Package cache_pkg holds WORD_W, LINE_WORDS, LINE_ADDR_W defaults and the responder state enum. The cache controller uses the same package.
REQ-021 One sub-module, mem_word_array: single-port synchronous RAM, 2**(LINE_ADDR_W+3) words of WORD_W bits, with write enable and registered read data. The beat pipeline absorbs its 1-cycle read latency so REQ-012 still holds.

Verification
REQ-022 Write then read: mem_write, addr 0x05, words 0x1000..0x1007 -> ca_resp at T+9; then mem_read, addr 0x05 -> rd_line words 0x1000..0x1007, ca_resp at T+9.
REQ-023 Aliasing: write addr 0x00 all 0xAAAAAAAA, write addr 0xFF all 0x55555555 -> read 0x00 returns all 0xAAAAAAAA; read 0xFF returns all 0x55555555.
REQ-024 Simultaneous request: mem_read=mem_write=1 in IDLE -> error one cycle, busy stays 0, no ca_resp, array unchanged.
REQ-025 Request during burst: mem_read at beat 3 of a write to 0x10 -> error one cycle; the write completes with ca_resp at T+9; exactly one ca_resp seen.
REQ-026 Reset mid-read: rst low at beat 4 -> ca_resp 0, busy 0, rd_line 0 immediately; the next read to 0x05 returns 0x1000..0x1007.
REQ-027 Back-to-back: write at T, read of the same line issued at T+10 -> read returns the written data, ca_resp at T+19.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared cache geometry defaults and the line responder state encoding.
// Imported by the responder, its word array and the cache controller.
package cache_pkg;

   localparam int WORD_W      = 32;
   localparam int LINE_WORDS  = 8;
   localparam int LINE_ADDR_W = 8;

   // 3-bit encoding leaves spare codes that the FSM traps back to IDLE
   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_RD_BURST = 3'd1,
      ST_WR_BURST = 3'd2,
      ST_RESP     = 3'd3
   } resp_state_t;

endpackage

// File: rtl/mem_word_array.sv
// Single-port synchronous word RAM with registered read data.
// Contents are deliberately not reset.
module mem_word_array #(
   parameter int WORD_W = 32,
   parameter int ADDR_W = 11
) (
   input  logic              clk,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [WORD_W-1:0] i_wdata,
   output logic [WORD_W-1:0] o_rdata
);

   logic [WORD_W-1:0] r_mem [2**ADDR_W];
   logic [WORD_W-1:0] r_rdata;

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_addr] <= i_wdata;
      end
      r_rdata <= r_mem[i_addr];
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_line_responder.sv
// Line-fill / write-back responder: bursts one word per cycle to a
// word array, then pulses ca_resp; bad requests pulse error.
module mem_line_responder #(
   parameter int WORD_W      = cache_pkg::WORD_W,
   parameter int LINE_WORDS  = cache_pkg::LINE_WORDS,
   parameter int LINE_ADDR_W = cache_pkg::LINE_ADDR_W
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         mem_read,
   input  logic                         mem_write,
   input  logic [LINE_ADDR_W-1:0]       line_addr,
   input  logic [WORD_W*LINE_WORDS-1:0] wr_line,
   output logic [WORD_W*LINE_WORDS-1:0] rd_line,
   output logic                         ca_resp,
   output logic                         busy,
   output logic                         error
);

   import cache_pkg::*;

   localparam int BEAT_W = $clog2(LINE_WORDS);
   localparam int IDX_W  = LINE_ADDR_W + BEAT_W;

   resp_state_t                  r_state;
   logic [BEAT_W-1:0]            r_beat;
   logic [BEAT_W-1:0]            r_rd_beat;
   logic                         r_rd_vld;
   logic [LINE_ADDR_W-1:0]       r_addr;
   logic [WORD_W*LINE_WORDS-1:0] r_wline;

   logic                         w_we;
   logic                         w_req;
   logic [IDX_W-1:0]             w_idx;
   logic [WORD_W-1:0]            w_wdata;
   logic [WORD_W-1:0]            w_rdata;

   assign w_req   = mem_read | mem_write;
   assign w_we    = (r_state == ST_WR_BURST);
   assign w_idx   = {r_addr, r_beat};
   assign w_wdata = r_wline[r_beat*WORD_W +: WORD_W];

   mem_word_array #(
      .WORD_W (WORD_W),
      .ADDR_W (IDX_W)
   ) u_array (
      .clk     (clk),
      .i_we    (w_we),
      .i_addr  (w_idx),
      .i_wdata (w_wdata),
      .o_rdata (w_rdata)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= ST_IDLE;
         r_beat    <= '0;
         r_rd_beat <= '0;
         r_rd_vld  <= 1'b0;
         r_addr    <= '0;
         r_wline   <= '0;
         rd_line   <= '0;
         ca_resp   <= 1'b0;
         busy      <= 1'b0;
         error     <= 1'b0;
      end else begin
         ca_resp  <= 1'b0;
         error    <= 1'b0;
         r_rd_vld <= 1'b0;
         // read data lags the array address by one cycle
         if (r_rd_vld) begin
            rd_line[r_rd_beat*WORD_W +: WORD_W] <= w_rdata;
         end
         case (r_state)
            ST_IDLE: begin
               if (mem_read && mem_write) begin
                  error <= 1'b1;
               end else if (mem_read) begin
                  r_addr  <= line_addr;
                  r_beat  <= '0;
                  busy    <= 1'b1;
                  r_state <= ST_RD_BURST;
               end else if (mem_write) begin
                  r_addr  <= line_addr;
                  r_wline <= wr_line;
                  r_beat  <= '0;
                  busy    <= 1'b1;
                  r_state <= ST_WR_BURST;
               end
            end
            ST_RD_BURST: begin
               error     <= w_req;
               r_rd_vld  <= 1'b1;
               r_rd_beat <= r_beat;
               r_beat    <= r_beat + 1'b1;
               if (&r_beat) begin
                  r_state <= ST_RESP;
               end
            end
            ST_WR_BURST: begin
               error  <= w_req;
               r_beat <= r_beat + 1'b1;
               if (&r_beat) begin
                  r_state <= ST_RESP;
               end
            end
            ST_RESP: begin
               error   <= w_req;
               ca_resp <= 1'b1;
               busy    <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: begin
               error   <= 1'b1;
               busy    <= 1'b0;
               r_beat  <= '0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_line_responder.sv
// Directed bench for mem_line_responder: table of line transactions
// plus hand-built sequences for error, mid-burst and reset cases.
module tb_mem_line_responder;

   typedef logic [255:0] line_t;

   typedef struct {
      bit    wr;
      logic [7:0] addr;
      line_t wline;
      line_t exp_rd;
   } vec_t;

   logic       clk;
   logic       rst;
   logic       mem_read;
   logic       mem_write;
   logic [7:0] line_addr;
   line_t      wr_line;
   line_t      rd_line;
   logic       ca_resp;
   logic       busy;
   logic       error;

   int n_chk;
   int n_err;

   mem_line_responder dut (
      .clk       (clk),
      .rst       (rst),
      .mem_read  (mem_read),
      .mem_write (mem_write),
      .line_addr (line_addr),
      .wr_line   (wr_line),
      .rd_line   (rd_line),
      .ca_resp   (ca_resp),
      .busy      (busy),
      .error     (error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic line_t mk_line(input logic [31:0] base,
                                     input logic [31:0] inc);
      line_t l;
      for (int i = 0; i < 8; i++) begin
         l[i*32 +: 32] = base + inc * i;
      end
      return l;
   endfunction

   task automatic chk(input string name, input line_t act,
                      input line_t exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // issue one request, return edges from sampling edge to ca_resp
   task automatic run_req(input bit rd, input bit wr,
                          input logic [7:0] a, input line_t wl,
                          output int lat);
      @(negedge clk);
      mem_read  = rd;
      mem_write = wr;
      line_addr = a;
      wr_line   = wl;
      @(posedge clk);
      #1;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      chk("busy_after_accept", line_t'(busy), line_t'(1'b1));
      lat = 0;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk);
         #1;
         if (ca_resp === 1'b1) begin
            lat = k;
            break;
         end
      end
      if (lat == 0) begin
         n_chk++;
         n_err++;
         $display("FAIL resp_timeout: no ca_resp within 20 cycles");
      end
   endtask

   vec_t  vecs[6];
   line_t l1000;
   line_t laaaa;
   line_t l5555;
   line_t l2000;
   int    lat;
   int    rcnt;
   int    elat;
   logic  err_seen;

   initial begin
      l1000 = mk_line(32'h1000, 32'h1);
      laaaa = mk_line(32'hAAAAAAAA, 32'h0);
      l5555 = mk_line(32'h55555555, 32'h0);
      l2000 = mk_line(32'h2000, 32'h1);

      vecs[0] = '{wr: 1'b1, addr: 8'h05, wline: l1000, exp_rd: '0};
      vecs[1] = '{wr: 1'b0, addr: 8'h05, wline: '0,    exp_rd: l1000};
      vecs[2] = '{wr: 1'b1, addr: 8'h00, wline: laaaa, exp_rd: l1000};
      vecs[3] = '{wr: 1'b1, addr: 8'hFF, wline: l5555, exp_rd: l1000};
      vecs[4] = '{wr: 1'b0, addr: 8'h00, wline: '0,    exp_rd: laaaa};
      vecs[5] = '{wr: 1'b0, addr: 8'hFF, wline: '0,    exp_rd: l5555};

      n_chk     = 0;
      n_err     = 0;
      rst       = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      line_addr = '0;
      wr_line   = '0;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_ca_resp", line_t'(ca_resp), '0);
      chk("rst_busy", line_t'(busy), '0);
      chk("rst_error", line_t'(error), '0);
      chk("rst_rd_line", rd_line, '0);
      @(negedge clk);
      rst = 1'b1;

      // vec 0 -> 1 also exercises a read issued right after write resp
      foreach (vecs[i]) begin
         run_req(!vecs[i].wr, vecs[i].wr, vecs[i].addr,
                 vecs[i].wline, lat);
         chk($sformatf("vec%0d_latency", i), line_t'(lat), line_t'(9));
         chk($sformatf("vec%0d_busy_at_resp", i),
             line_t'(busy), '0);
         chk($sformatf("vec%0d_rd_line", i), rd_line, vecs[i].exp_rd);
      end

      // both requests in IDLE
      @(negedge clk);
      mem_read  = 1'b1;
      mem_write = 1'b1;
      line_addr = 8'h05;
      wr_line   = mk_line(32'hDEAD0000, 32'h1);
      @(posedge clk);
      #1;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      chk("both_error", line_t'(error), line_t'(1'b1));
      chk("both_busy", line_t'(busy), '0);
      @(posedge clk);
      #1;
      chk("both_error_clears", line_t'(error), '0);
      rcnt = 0;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk);
         #1;
         if (ca_resp === 1'b1 || busy === 1'b1) rcnt++;
      end
      chk("both_no_activity", line_t'(rcnt), '0);
      run_req(1'b1, 1'b0, 8'h05, '0, lat);
      chk("both_array_unchanged", rd_line, l1000);

      // read request at beat 3 of a write burst to 0x10
      @(negedge clk);
      mem_write = 1'b1;
      line_addr = 8'h10;
      wr_line   = l2000;
      @(posedge clk);
      #1;
      mem_write = 1'b0;
      rcnt      = 0;
      elat      = 0;
      err_seen  = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         mem_read  = (k == 4);
         line_addr = 8'h05;
         @(posedge clk);
         #1;
         mem_read = 1'b0;
         if (k == 4) err_seen = error;
         if (ca_resp === 1'b1) begin
            rcnt++;
            if (elat == 0) elat = k;
         end
      end
      chk("burst_req_error", line_t'(err_seen), line_t'(1'b1));
      chk("burst_resp_count", line_t'(rcnt), line_t'(1));
      chk("burst_latency", line_t'(elat), line_t'(9));
      chk("burst_rd_line_kept", rd_line, l1000);
      run_req(1'b1, 1'b0, 8'h10, '0, lat);
      chk("burst_write_data", rd_line, l2000);

      // reset at beat 4 of a read of 0xFF
      @(negedge clk);
      mem_read  = 1'b1;
      line_addr = 8'hFF;
      @(posedge clk);
      #1;
      mem_read = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("midrst_ca_resp", line_t'(ca_resp), '0);
      chk("midrst_busy", line_t'(busy), '0);
      chk("midrst_rd_line", rd_line, '0);
      @(negedge clk);
      rst  = 1'b1;
      rcnt = 0;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk);
         #1;
         if (ca_resp === 1'b1) rcnt++;
      end
      chk("midrst_no_resp", line_t'(rcnt), '0);
      run_req(1'b1, 1'b0, 8'h05, '0, lat);
      chk("midrst_next_latency", line_t'(lat), line_t'(9));
      chk("midrst_next_read", rd_line, l1000);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
